// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing one 4:1 mux lane.
// A grant lasts at most HOLD transfers; the selected lane is registered onto Y.
module mux_rr_arbiter #(
  parameter int W    = 1,
  parameter int HOLD = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] D,
  output logic [3:0]     gnt,
  output logic [1:0]     S,
  output logic [W-1:0]   Y,
  output logic           y_valid
);

  localparam int CW = $clog2(HOLD + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    s_q, s_d;
  logic [W-1:0]  y_q, y_d;
  logic          y_valid_q, y_valid_d;

  logic          xfer_s;
  logic          grant_end_s;
  logic [CW-1:0] cnt_inc_s;
  logic [1:0]    search_base_s;
  logic          found_s;
  logic [1:0]    win_s;

  // First set bit of r scanning base, base+1, base+2, base+3 (mod 4); MSB flags a hit.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic       found;
    logic [1:0] win;
    logic [1:0] idx;
    found = 1'b0;
    win   = base;
    for (int k = 0; k < 4; k++) begin
      idx   = base + 2'(k);
      win   = (r[idx] && !found) ? idx : win;
      found = found | r[idx];
    end
    return {found, win};
  endfunction

  // Transfer detection, grant-end condition and winner search.
  always_comb begin
    xfer_s        = (state_q == GRANT) && req[s_q];
    cnt_inc_s     = cnt_q + CW'(1);
    grant_end_s   = (state_q == GRANT) &&
                    (!req[s_q] || (cnt_inc_s == CW'(HOLD)));
    // Ending grant searches S+1, S+2, S+3, S; idle search starts at the pointer.
    search_base_s = (state_q == GRANT) ? (s_q + 2'd1) : ptr_q;
    {found_s, win_s} = rr_pick(req, search_base_s);
  end

  // Next-state and output register inputs.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    s_d       = s_q;
    y_d       = y_q;
    y_valid_d = 1'b0;

    if (xfer_s) begin
      y_d       = D[s_q*W +: W];
      y_valid_d = 1'b1;
      cnt_d     = cnt_inc_s;
    end else begin
      y_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win_s;
          s_d     = win_s;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
        end
      end
      GRANT: begin
        if (grant_end_s) begin
          ptr_d = s_q + 2'd1;
          cnt_d = {CW{1'b0}};
          if (found_s) begin
            state_d = GRANT;
            gnt_d   = 4'b0001 << win_s;
            s_d     = win_s;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
          end
        end else begin
          state_d = GRANT;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      cnt_q     <= {CW{1'b0}};
      gnt_q     <= 4'b0000;
      s_q       <= 2'd0;
      y_q       <= {W{1'b0}};
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      s_q       <= s_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign gnt     = gnt_q;
  assign S       = s_q;
  assign Y       = y_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: HOLD=4 instance plus a HOLD=1 instance
// sharing the same inputs.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] D;

  logic [3:0] gnt_a, gnt_b;
  logic [1:0] s_a, s_b;
  logic [0:0] y_a, y_b;
  logic       yv_a, yv_b;

  int n_checks;
  int n_errors;

  mux_rr_arbiter #(.W(1), .HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .D(D),
    .gnt(gnt_a), .S(s_a), .Y(y_a), .y_valid(yv_a)
  );

  mux_rr_arbiter #(.W(1), .HOLD(1)) dut_h1 (
    .clk(clk), .rst(rst), .req(req), .D(D),
    .gnt(gnt_b), .S(s_b), .Y(y_b), .y_valid(yv_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    req = 4'b0000;
    D   = 4'b0001;

    // Reset held two cycles with all requests high.
    rst = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("rst_gnt", 32'(gnt_a), 32'h0);
      check("rst_s",   32'(s_a),   32'h0);
      check("rst_y",   32'(y_a),   32'h0);
      check("rst_yv",  32'(yv_a),  32'h0);
    end
    rst = 1'b0;
    tick();
    check("rel_gnt", 32'(gnt_a), 32'h1);
    check("rel_yv",  32'(yv_a),  32'h0);

    // Single requester: continuous back-to-back grants, no y_valid gaps.
    do_reset();
    D   = 4'b0001;
    req = 4'b0001;
    tick();
    check("single_gnt1", 32'(gnt_a), 32'h1);
    check("single_yv1",  32'(yv_a),  32'h0);
    for (int k = 2; k <= 10; k++) begin
      tick();
      check("single_gnt", 32'(gnt_a), 32'h1);
      check("single_y",   32'(y_a),   32'h1);
      check("single_yv",  32'(yv_a),  32'h1);
    end

    // Two requesters alternate every 4 transfers with no idle cycle.
    do_reset();
    D   = 4'b0100;
    req = 4'b0101;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("two_gnt", 32'(gnt_a), ((((k - 1) / 4) % 2) == 0) ? 32'h1 : 32'h4);
      if (k >= 2) begin
        check("two_y",  32'(y_a),  ((((k - 2) / 4) % 2) == 0) ? 32'h0 : 32'h1);
        check("two_yv", 32'(yv_a), 32'h1);
      end
    end

    // HOLD=1 full rotation.
    do_reset();
    D   = 4'b0001;
    req = 4'b1111;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("rot_s", 32'(s_b), 32'((k - 1) % 4));
      if (k >= 2) begin
        check("rot_y", 32'(y_b), (((k - 2) % 4) == 0) ? 32'h1 : 32'h0);
      end
    end

    // Withdrawal after two transfers on lane 2; lane 3 takes over.
    do_reset();
    D   = 4'b1000;
    req = 4'b0100;
    tick();
    check("wd_gnt", 32'(gnt_a), 32'h4);
    check("wd_s",   32'(s_a),   32'h2);
    tick();
    check("wd_yv1", 32'(yv_a), 32'h1);
    tick();
    check("wd_yv2", 32'(yv_a), 32'h1);
    req = 4'b1000;
    tick();
    check("wd_gap",  32'(yv_a),  32'h0);
    check("wd_gnt3", 32'(gnt_a), 32'h8);
    check("wd_s3",   32'(s_a),   32'h3);
    tick();
    check("wd_yv3", 32'(yv_a), 32'h1);
    check("wd_y3",  32'(y_a),  32'h1);

    // Reset pulse during the third transfer of lane 2.
    do_reset();
    D   = 4'b0100;
    req = 4'b0100;
    tick();
    tick();
    tick();
    check("mr_yv_pre", 32'(yv_a), 32'h1);
    rst = 1'b1;
    tick();
    check("mr_gnt", 32'(gnt_a), 32'h0);
    check("mr_s",   32'(s_a),   32'h0);
    check("mr_y",   32'(y_a),   32'h0);
    check("mr_yv",  32'(yv_a),  32'h0);
    rst = 1'b0;
    tick();
    check("mr_regnt", 32'(gnt_a), 32'h4);
    check("mr_res",   32'(s_a),   32'h2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
